// File: rtl/alu_pkg.sv
// Shared ALU constants and types.
// Used by the multi-cycle rotate units.
package alu_pkg;

    localparam int WORD_W    = 32;
    localparam int ROT_AMT_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        ROTATE,
        DONE
    } rol_state_t;

endpackage

// File: rtl/rol_step.sv
// Combinational rotate-left of WIDTH bits by 0..STEP positions.
// Shared step primitive for the multi-cycle rotate units.
module rol_step
    import alu_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int STEP  = 1,
    localparam int SW   = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [SW-1:0]    amt,
    output logic [WIDTH-1:0] result
);

    logic [2*WIDTH-1:0] dbl;

    // Bits shifted out of the top half reappear in the low end.
    assign dbl    = {data, data} << amt;
    assign result = dbl[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/rol_seq.sv
// Multi-cycle rotate-left unit with start/busy/done handshake.
// Rotates by up to STEP bits per clock; result held in data_out.
module rol_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int AMT_W = ROT_AMT_W,
    parameter int STEP  = 1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AMT_W-1:0] numOfRotateBits,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out
);

    localparam int SW = $clog2(STEP + 1);
    localparam logic [AMT_W-1:0] STEP_C = AMT_W'(STEP);

    rol_state_t       state;
    logic [WIDTH-1:0] work;
    logic [AMT_W-1:0] remaining;
    logic [AMT_W-1:0] k;
    logic [WIDTH-1:0] rot;

    // Clamp keeps the final partial step from overshooting.
    assign k = (remaining > STEP_C) ? STEP_C : remaining;

    rol_step #(
        .WIDTH(WIDTH),
        .STEP (STEP)
    ) u_step (
        .data  (work),
        .amt   (k[SW-1:0]),
        .result(rot)
    );

    assign data_out = work;

    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= IDLE;
            work      <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        work      <= data_in;
                        remaining <= numOfRotateBits;
                        if (numOfRotateBits != '0) begin
                            state <= ROTATE;
                            busy  <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ROTATE: begin
                    work      <= rot;
                    remaining <= remaining - k;
                    if (remaining == k) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rol_seq.sv
// Self-checking bench for rol_seq: STEP=1 and STEP=4 instances
// driven independently and compared against a cycle-level reference.
module tb_rol_seq;

    logic        clock = 1'b0;
    logic        clr [2];
    logic        st  [2];
    logic [31:0] din [2];
    logic [4:0]  cnt [2];
    logic        bz  [2];
    logic        dn  [2];
    logic [31:0] dq  [2];

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    rol_seq #(.WIDTH(32), .AMT_W(5), .STEP(1)) u_s1 (
        .clock          (clock),
        .clear          (clr[0]),
        .start          (st[0]),
        .data_in        (din[0]),
        .numOfRotateBits(cnt[0]),
        .busy           (bz[0]),
        .done           (dn[0]),
        .data_out       (dq[0])
    );

    rol_seq #(.WIDTH(32), .AMT_W(5), .STEP(4)) u_s4 (
        .clock          (clock),
        .clear          (clr[1]),
        .start          (st[1]),
        .data_in        (din[1]),
        .numOfRotateBits(cnt[1]),
        .busy           (bz[1]),
        .done           (dn[1]),
        .data_out       (dq[1])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h want %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] d, input int n);
        if (n == 0) return d;
        return (d << n) | (d >> (32 - n));
    endfunction

    function automatic int stp(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    // Caller is at a negedge with the target instance idle.
    task automatic run_op(input int i, input logic [31:0] d, input int n,
                          input int ign_c);
        logic [31:0] exp;
        int nc;
        exp = rotl(d, n);
        nc  = (n + stp(i) - 1) / stp(i);
        st[i]  = 1'b1;
        din[i] = d;
        cnt[i] = 5'(n);
        for (int c = 1; c <= nc + 2; c++) begin
            @(negedge clock);
            st[i]  = 1'b0;
            din[i] = $urandom;
            cnt[i] = 5'($urandom);
            if (c == ign_c) st[i] = 1'b1;
            chk($sformatf("busy i%0d n%0d c%0d", i, n, c),
                32'(bz[i]), 32'(c <= nc));
            chk($sformatf("done i%0d n%0d c%0d", i, n, c),
                32'(dn[i]), 32'(c == nc + 1));
            if (c >= nc + 1)
                chk($sformatf("data i%0d n%0d c%0d", i, n, c), dq[i], exp);
        end
    endtask

    task automatic idle_chk(input int i, input string tag);
        chk({tag, " busy"}, 32'(bz[i]), 32'd0);
        chk({tag, " done"}, 32'(dn[i]), 32'd0);
        chk({tag, " data"}, dq[i], 32'd0);
    endtask

    task automatic clear_mid(input int i);
        st[i]  = 1'b1;
        din[i] = 32'h0000FFFF;
        cnt[i] = 5'd20;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clock);
            st[i]  = 1'b0;
            clr[i] = (c == 5);
            if (c <= 5 && c <= (20 + stp(i) - 1) / stp(i))
                chk($sformatf("pre-clr busy i%0d c%0d", i, c),
                    32'(bz[i]), 32'd1);
            if (c >= 6) idle_chk(i, $sformatf("post-clr i%0d c%0d", i, c));
        end
    endtask

    initial begin
        int i, n, nc, ign;
        for (int j = 0; j < 2; j++) begin
            clr[j] = 1'b1;
            st[j]  = 1'b0;
            din[j] = '0;
            cnt[j] = '0;
        end
        repeat (2) @(negedge clock);
        idle_chk(0, "reset s1");
        idle_chk(1, "reset s4");
        clr[0] = 1'b0;
        clr[1] = 1'b0;
        @(negedge clock);

        run_op(0, 32'h80000001, 1, 0);
        run_op(0, 32'hDEADBEEF, 0, 0);
        run_op(1, 32'hDEADBEEF, 0, 0);
        run_op(0, 32'h12345678, 8, 4);
        run_op(1, 32'h00000001, 31, 0);
        clear_mid(0);
        clear_mid(1);
        run_op(0, 32'hF0000000, 4, 0);
        run_op(0, 32'h0000000F, 28, 0);
        run_op(1, 32'hF0000000, 4, 0);
        run_op(1, 32'h0000000F, 28, 0);

        for (int t = 0; t < 60; t++) begin
            i   = int'($urandom_range(1, 0));
            n   = int'($urandom_range(31, 0));
            nc  = (n + stp(i) - 1) / stp(i);
            ign = ($urandom_range(1, 0) == 1) ?
                  int'($urandom_range(nc + 1, 1)) : 0;
            run_op(i, $urandom, n, ign);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
